// File: rtl/ps2_scancode_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder_pkg
// Shared PS/2 Set-2 definitions. Both the scan-code decoder and the receive
// stage import this package.
//   - prefix bytes (E0 extended, F0 break, E1 pause)
//   - keyboard control/response bytes and a classifier function
//   - the fake-shift codes that PrtScr and the numpad wrap around their keys
//   - decoder FSM state encoding
//   - the expected Pause bytes, indexed by position 1..7 after the leading E1
// ---------------------------------------------------------------------------
package ps2_scancode_decoder_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    localparam logic [7:0] PS2_CTRL_ERR0   = 8'h00;
    localparam logic [7:0] PS2_CTRL_BATOK  = 8'hAA;
    localparam logic [7:0] PS2_CTRL_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_CTRL_ACK    = 8'hFA;
    localparam logic [7:0] PS2_CTRL_BATERR = 8'hFC;
    localparam logic [7:0] PS2_CTRL_RESEND = 8'hFE;
    localparam logic [7:0] PS2_CTRL_ERR1   = 8'hFF;

    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_PAUSE    = 3'd4
    } state_t;

    // Control/response bytes are side-band traffic from the keyboard and are
    // never part of a scan-code sequence.
    function automatic logic isCtrlByte(input logic [7:0] b);
        logic res;
        case (b)
            PS2_CTRL_ERR0, PS2_CTRL_BATOK, PS2_CTRL_ECHO, PS2_CTRL_ACK,
            PS2_CTRL_BATERR, PS2_CTRL_RESEND, PS2_CTRL_ERR1: res = 1'b1;
            default:                                         res = 1'b0;
        endcase
        return res;
    endfunction

    // Pause sends E1 14 77 E1 F0 14 F0 77; this returns the byte expected at
    // position idx once the leading E1 has been consumed.
    function automatic logic [7:0] pauseByte(input logic [2:0] idx);
        logic [7:0] res;
        case (idx)
            3'd1:    res = 8'h14;
            3'd2:    res = 8'h77;
            3'd3:    res = 8'hE1;
            3'd4:    res = 8'hF0;
            3'd5:    res = 8'h14;
            3'd6:    res = 8'hF0;
            3'd7:    res = 8'h77;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// ---------------------------------------------------------------------------
// ps2_seq_timer
// Idle timer for a partially received scan-code sequence. Counts the cycles
// spent with run high and raises expire during the cycle in which the count
// has reached TIMEOUT_CYCLES-1 while run is still high.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low reset
//   clear  in   restart the count from zero
//   run    in   count this cycle (sequence pending, no byte arriving)
//   expire out  one-cycle expiry strobe (combinational from the count)
// ---------------------------------------------------------------------------
module ps2_seq_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign expire = run && (r_count == LAST_COUNT);

    // The counter restarts after each expiry; the owner drops back to idle on
    // that same edge, so the next count only starts with a fresh sequence.
    always_ff @(posedge clk) begin
        if (!reset || clear || expire) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
// Turns the byte stream from the PS/2 receive stage into Set-2 key events
// (code + extended + break), a Pause pulse, control-byte reports and error
// pulses for malformed or stale sequences.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   rx_data[7:0] in   received byte
//   rx_valid     in   one-cycle strobe qualifying rx_data
//   key_code     out  scan code of the last key event (held)
//   key_ext      out  last key event was E0-prefixed (held)
//   key_break    out  last key event was a release (held)
//   key_valid    out  one-cycle key event strobe
//   key_pause    out  one-cycle strobe, full Pause sequence seen
//   ctrl_code    out  last control/response byte (held)
//   ctrl_valid   out  one-cycle control byte strobe
//   err_seq      out  one-cycle strobe, illegal byte inside a sequence
//   err_timeout  out  one-cycle strobe, partial sequence abandoned
// ---------------------------------------------------------------------------
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 100000,
    parameter bit FILTER_FAKE_SHIFT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       key_pause,
    output logic [7:0] ctrl_code,
    output logic       ctrl_valid,
    output logic       err_seq,
    output logic       err_timeout
);

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_idx;
    logic [2:0] w_nextIdx;

    logic [7:0] r_keyCode;
    logic       r_keyExt;
    logic       r_keyBreak;
    logic       r_keyValid;
    logic       r_keyPause;
    logic [7:0] r_ctrlCode;
    logic       r_ctrlValid;
    logic       r_errSeq;
    logic       r_errTimeout;

    logic w_keyValid;
    logic w_keyExt;
    logic w_keyBreak;
    logic w_pause;
    logic w_errSeq;

    logic w_isCtrl;
    logic w_dataByte;
    logic w_isPrefix;
    logic w_isFake;
    logic w_pauseMatch;
    logic w_expire;
    logic w_timerClear;
    logic w_timerRun;

    assign w_isCtrl     = rx_valid && isCtrlByte(rx_data);
    assign w_dataByte   = rx_valid && !isCtrlByte(rx_data);
    assign w_isPrefix   = (rx_data == PS2_E0) || (rx_data == PS2_F0) || (rx_data == PS2_E1);
    assign w_isFake     = FILTER_FAKE_SHIFT &&
                          ((rx_data == PS2_FAKE_LSHIFT) || (rx_data == PS2_FAKE_RSHIFT));
    assign w_pauseMatch = (rx_data == pauseByte(r_idx));

    // Control bytes neither restart nor advance the timer: a byte arriving on
    // the expiry cycle always pre-empts the timeout.
    assign w_timerClear = w_dataByte || (r_state == ST_IDLE);
    assign w_timerRun   = (r_state != ST_IDLE) && !rx_valid;

    ps2_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_timerClear),
        .run   (w_timerRun),
        .expire(w_expire)
    );

    // State register plus registered outputs. Code/flag outputs only load on
    // their strobe so they hold between events.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_keyCode    <= '0;
            r_keyExt     <= 1'b0;
            r_keyBreak   <= 1'b0;
            r_keyValid   <= 1'b0;
            r_keyPause   <= 1'b0;
            r_ctrlCode   <= '0;
            r_ctrlValid  <= 1'b0;
            r_errSeq     <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_idx        <= w_nextIdx;
            r_keyValid   <= w_keyValid;
            r_keyPause   <= w_pause;
            r_ctrlValid  <= w_isCtrl;
            r_errSeq     <= w_errSeq;
            r_errTimeout <= w_expire;
            if (w_keyValid) begin
                r_keyCode  <= rx_data;
                r_keyExt   <= w_keyExt;
                r_keyBreak <= w_keyBreak;
            end
            if (w_isCtrl) begin
                r_ctrlCode <= rx_data;
            end
        end
    end

    // Next-state logic. Outside PAUSE a prefix byte always restarts the
    // sequence from that prefix, which covers both the normal path and the
    // "treat as if in IDLE" recovery after an illegal prefix.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        if (w_dataByte) begin
            case (r_state)
                ST_PAUSE: begin
                    if (w_pauseMatch && (r_idx != 3'd7)) begin
                        w_nextIdx = r_idx + 3'd1;
                    end else begin
                        w_nextState = ST_IDLE;
                        w_nextIdx   = '0;
                    end
                end
                default: begin
                    if (rx_data == PS2_E0) begin
                        w_nextState = ST_GOT_E0;
                    end else if (rx_data == PS2_F0) begin
                        w_nextState = (r_state == ST_GOT_E0) ? ST_GOT_E0F0 : ST_GOT_F0;
                    end else if (rx_data == PS2_E1) begin
                        w_nextState = ST_PAUSE;
                        w_nextIdx   = 3'd1;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            endcase
        end else if (w_expire) begin
            w_nextState = ST_IDLE;
            w_nextIdx   = '0;
        end
    end

    // Event decode for the byte being consumed this cycle. Only the E0 F0
    // prefix is legal after E0; every other repeated prefix is an error.
    always_comb begin
        w_keyValid = 1'b0;
        w_keyExt   = 1'b0;
        w_keyBreak = 1'b0;
        w_pause    = 1'b0;
        w_errSeq   = 1'b0;
        if (w_dataByte) begin
            case (r_state)
                ST_IDLE: begin
                    w_keyValid = !w_isPrefix;
                end
                ST_GOT_E0: begin
                    if (rx_data == PS2_F0) begin
                        w_errSeq = 1'b0;
                    end else if (w_isPrefix) begin
                        w_errSeq = 1'b1;
                    end else begin
                        w_keyExt   = 1'b1;
                        w_keyValid = !w_isFake;
                    end
                end
                ST_GOT_F0: begin
                    if (w_isPrefix) begin
                        w_errSeq = 1'b1;
                    end else begin
                        w_keyBreak = 1'b1;
                        w_keyValid = 1'b1;
                    end
                end
                ST_GOT_E0F0: begin
                    if (w_isPrefix) begin
                        w_errSeq = 1'b1;
                    end else begin
                        w_keyExt   = 1'b1;
                        w_keyBreak = 1'b1;
                        w_keyValid = !w_isFake;
                    end
                end
                ST_PAUSE: begin
                    if (!w_pauseMatch) begin
                        w_errSeq = 1'b1;
                    end else if (r_idx == 3'd7) begin
                        w_pause = 1'b1;
                    end
                end
                default: begin
                    w_errSeq = 1'b0;
                end
            endcase
        end
    end

    assign key_code    = r_keyCode;
    assign key_ext     = r_keyExt;
    assign key_break   = r_keyBreak;
    assign key_valid   = r_keyValid;
    assign key_pause   = r_keyPause;
    assign ctrl_code   = r_ctrlCode;
    assign ctrl_valid  = r_ctrlValid;
    assign err_seq     = r_errSeq;
    assign err_timeout = r_errTimeout;

endmodule
